tetris_board_engine: RTL and testbench

Parametrised single-clock playfield engine for the tetris chip. It replaces the fixed 32-bit board path with a COLS x ROWS board and keeps the same move encoding. It adds gravity timing, hard drop, multi-row line clearing, a line counter and game-over detection. It sits between the input controller (in_move) and the display/output path (out_board).

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/tetris_gravity_tick.sv | 30 +++
 rtl/tetris_board_engine.sv | 167 ++++++++++++++++
 tb/tb_tetris_board_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and helpers for the tetris playfield engine.
// Cell (row, col) maps to board bit row*cols+col, with row 0 at the top.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_SPAWN = 3'd0,
        ST_FALL  = 3'd1,
        ST_DROP  = 3'd2,
        ST_LOCK  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [1:0] MOVE_NONE  = 2'd0;
    localparam logic [1:0] MOVE_LEFT  = 2'd1;
    localparam logic [1:0] MOVE_RIGHT = 2'd2;
    localparam logic [1:0] MOVE_DROP  = 2'd3;

    function automatic int unsigned cell_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/tetris_gravity_tick.sv
// Gravity divider: counts enabled cycles and pulses on the terminal count,
// wrapping back to zero in the same cycle. Clear has priority over enable.
module tetris_gravity_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic pulse
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign pulse = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= pulse ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tetris_board_engine.sv
// Single-cell tetris playfield: gravity, lateral moves, hard drop,
// multi-row line clearing, line counter and game-over detection.
module tetris_board_engine
    import tetris_pkg::*;
#(
    parameter int COLS      = 4,
    parameter int ROWS      = 8,
    parameter int TICK_DIV  = 4,
    parameter int SPAWN_COL = 1
) (
    input  logic                 in_clk,
    input  logic                 in_restart_n,
    input  logic [1:0]           in_move,
    output logic [COLS*ROWS-1:0] out_board,
    output logic                 out_game_over,
    output logic [7:0]           out_lines,
    output logic                 out_busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);

    state_t           state, state_d;
    logic [CELLS-1:0] board, board_d;
    logic [RW-1:0]    row, row_d;
    logic [CW-1:0]    col, col_d;
    logic             valid, valid_d;
    logic [RW-1:0]    scan, scan_d;
    logic [7:0]       lines, lines_d;

    logic tick_clr, tick_en, tick_pulse;
    int   row_i, col_i, scan_i, lat_col;
    logic blocked;

    // Cells outside the board read as empty; callers check edges themselves.
    function automatic logic occupied(input logic [CELLS-1:0] b, input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        return b[cell_idx(r, c, COLS)];
    endfunction

    function automatic logic row_full(input logic [CELLS-1:0] b, input int r);
        logic f;
        f = 1'b1;
        for (int c = 0; c < COLS; c++) f &= b[cell_idx(r, c, COLS)];
        return f;
    endfunction

    assign tick_clr = (state == ST_SPAWN);
    assign tick_en  = (state == ST_FALL) && (in_move != MOVE_DROP);

    tetris_gravity_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (in_clk),
        .rst_n (in_restart_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .pulse (tick_pulse)
    );

    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state <= ST_SPAWN;
            board <= '0;
            row   <= '0;
            col   <= '0;
            valid <= 1'b0;
            scan  <= '0;
            lines <= '0;
        end else begin
            state <= state_d;
            board <= board_d;
            row   <= row_d;
            col   <= col_d;
            valid <= valid_d;
            scan  <= scan_d;
            lines <= lines_d;
        end
    end

    always_comb begin
        state_d = state;
        board_d = board;
        row_d   = row;
        col_d   = col;
        valid_d = valid;
        scan_d  = scan;
        lines_d = lines;
        row_i   = int'(row);
        col_i   = int'(col);
        scan_i  = int'(scan);
        lat_col = int'(col);
        blocked = 1'b0;

        case (state)
            ST_SPAWN: begin
                if (occupied(board, 0, SPAWN_COL)) begin
                    state_d = ST_OVER;
                end else begin
                    row_d   = '0;
                    col_d   = CW'(SPAWN_COL);
                    valid_d = 1'b1;
                    state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                case (in_move)
                    MOVE_NONE: ;
                    MOVE_LEFT: begin
                        if (col_i > 0 && !occupied(board, row_i, col_i - 1)) lat_col = col_i - 1;
                    end
                    MOVE_RIGHT: begin
                        if (col_i < COLS - 1 && !occupied(board, row_i, col_i + 1)) lat_col = col_i + 1;
                    end
                    default: state_d = ST_DROP;
                endcase
                col_d = CW'(lat_col);
                // Gravity is judged at the column the piece just moved to.
                if (tick_pulse) begin
                    blocked = (row_i == ROWS - 1) || occupied(board, row_i + 1, lat_col);
                    if (blocked) state_d = ST_LOCK;
                    else         row_d   = RW'(row_i + 1);
                end
            end
            ST_DROP: begin
                blocked = (row_i == ROWS - 1) || occupied(board, row_i + 1, col_i);
                if (blocked) state_d = ST_LOCK;
                else         row_d   = RW'(row_i + 1);
            end
            ST_LOCK: begin
                board_d[cell_idx(row_i, col_i, COLS)] = 1'b1;
                valid_d = 1'b0;
                scan_d  = RW'(ROWS - 1);
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // A full row collapses everything above it; scan stays put so
                // the row that slid down is checked next cycle.
                if (row_full(board, scan_i)) begin
                    for (int r = 1; r < ROWS; r++) begin
                        if (r <= scan_i) begin
                            for (int c = 0; c < COLS; c++)
                                board_d[cell_idx(r, c, COLS)] = board[cell_idx(r - 1, c, COLS)];
                        end
                    end
                    for (int c = 0; c < COLS; c++) board_d[cell_idx(0, c, COLS)] = 1'b0;
                    if (lines != 8'hFF) lines_d = lines + 8'd1;
                end else if (scan_i == 0) begin
                    state_d = ST_SPAWN;
                end else begin
                    scan_d = scan - RW'(1);
                end
            end
            ST_OVER: ;
            default: state_d = ST_SPAWN;
        endcase
    end

    logic [CELLS-1:0] piece_mask;
    assign piece_mask = (valid && (state == ST_FALL || state == ST_DROP))
                        ? (CELLS'(1) << cell_idx(int'(row), int'(col), COLS)) : '0;

    assign out_board     = board | piece_mask;
    assign out_game_over = (state == ST_OVER);
    assign out_lines     = lines;
    assign out_busy      = (state == ST_LOCK) || (state == ST_CLEAR) || (state == ST_SPAWN);

endmodule

// File: tb/tb_tetris_board_engine.sv
// Directed bench for tetris_board_engine on a 4x8 board, TICK_DIV=4, spawn column 1.
module tb_tetris_board_engine;
    import tetris_pkg::*;

    logic        in_clk = 1'b0;
    logic        in_restart_n = 1'b0;
    logic [1:0]  in_move = MOVE_NONE;
    logic [31:0] out_board;
    logic        out_game_over;
    logic [7:0]  out_lines;
    logic        out_busy;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 in_clk = ~in_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    tetris_board_engine #(
        .COLS(4), .ROWS(8), .TICK_DIV(4), .SPAWN_COL(1)
    ) dut (
        .in_clk        (in_clk),
        .in_restart_n  (in_restart_n),
        .in_move       (in_move),
        .out_board     (out_board),
        .out_game_over (out_game_over),
        .out_lines     (out_lines),
        .out_busy      (out_busy)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_board(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_board(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s obs=empty_queue exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, out_board, e);
        end
    endtask

    task automatic expect_board(input string tag, input int n, input logic [31:0] v);
        push_board(v);
        step(n);
        check_board(tag);
    endtask

    task automatic do_reset(input string tag);
        in_move = MOVE_NONE;
        @(negedge in_clk);
        in_restart_n = 1'b0;
        #1;
        check_val({tag, "_rst_board"}, out_board, 32'h0);
        check_val({tag, "_rst_lines"}, 32'(out_lines), 32'h0);
        check_val({tag, "_rst_over"}, 32'(out_game_over), 32'h0);
        check_val({tag, "_rst_busy"}, 32'(out_busy), 32'h1);
        @(negedge in_clk);
        in_restart_n = 1'b1;
        expect_board({tag, "_spawn"}, 1, 32'h0000_0002);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        for (int i = 0; i < budget && !out_busy; i++) step(1);
        check_val(tag, 32'(out_busy), 32'h1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && out_busy; i++) step(1);
        check_val(tag, 32'(out_busy), 32'h0);
    endtask

    // Move from the spawn column to col, hard drop, and wait for the next piece.
    task automatic place(input string tag, input int col, input logic [31:0] exp_after);
        push_board(exp_after);
        if (col < 1) begin
            in_move = MOVE_LEFT;
            step(1 - col);
        end else if (col > 1) begin
            in_move = MOVE_RIGHT;
            step(col - 1);
        end
        in_move = MOVE_DROP;
        step(1);
        in_move = MOVE_NONE;
        wait_busy({tag, "_lock"}, 40);
        wait_idle({tag, "_idle"}, 40);
        check_board(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] col_model;

    initial begin
        // 1: gravity timing from reset
        #2;
        check_val("t1_rst_board", out_board, 32'h0);
        check_val("t1_rst_lines", 32'(out_lines), 32'h0);
        check_val("t1_rst_over", 32'(out_game_over), 32'h0);
        @(negedge in_clk);
        in_restart_n = 1'b1;
        expect_board("t1_spawn", 1, 32'h0000_0002);
        expect_board("t1_row7", 28, 32'h2000_0000);
        check_val("t1_row7_busy", 32'(out_busy), 32'h0);
        expect_board("t1_pre_lock", 3, 32'h2000_0000);
        expect_board("t1_lock", 1, 32'h0000_0000);
        check_val("t1_lock_busy", 32'(out_busy), 32'h1);
        expect_board("t1_clear", 1, 32'h2000_0000);
        check_val("t1_clear_busy", 32'(out_busy), 32'h1);
        expect_board("t1_to_spawn", 8, 32'h2000_0000);
        check_val("t1_spawn_busy", 32'(out_busy), 32'h1);
        expect_board("t1_respawn", 1, 32'h2000_0002);
        check_val("t1_respawn_busy", 32'(out_busy), 32'h0);

        // 2: lateral moves, edges and gravity interleaving
        in_move = MOVE_LEFT;
        expect_board("t2_left", 1, 32'h2000_0001);
        expect_board("t2_left_edge", 2, 32'h2000_0001);
        in_move = MOVE_RIGHT;
        expect_board("t2_right_fall", 1, 32'h2000_0020);
        expect_board("t2_right_c2", 1, 32'h2000_0040);
        expect_board("t2_right_c3", 1, 32'h2000_0080);
        expect_board("t2_right_edge", 1, 32'h2000_0080);
        expect_board("t2_right_fall2", 1, 32'h2000_0800);
        in_move = MOVE_NONE;

        // 2b: lateral move into an occupied cell
        do_reset("t2b");
        place("t2b_p0", 0, 32'h1000_0002);
        expect_board("t2b_row7", 28, 32'h3000_0000);
        in_move = MOVE_LEFT;
        expect_board("t2b_left_blocked", 1, 32'h3000_0000);
        in_move = MOVE_RIGHT;
        expect_board("t2b_right_free", 1, 32'h5000_0000);
        in_move = MOVE_NONE;
        wait_busy("t2b_lock", 10);
        push_board(32'h5000_0002);
        wait_idle("t2b_idle", 40);
        check_board("t2b_respawn");

        // 3: hard drop ignores in_move
        do_reset("t3");
        in_move = MOVE_DROP;
        expect_board("t3_drop_enter", 1, 32'h0000_0002);
        in_move = MOVE_LEFT;
        expect_board("t3_row6", 6, 32'h0200_0000);
        expect_board("t3_row7", 1, 32'h2000_0000);
        check_val("t3_row7_busy", 32'(out_busy), 32'h0);
        expect_board("t3_lock", 1, 32'h0000_0000);
        check_val("t3_lock_busy", 32'(out_busy), 32'h1);
        expect_board("t3_clear", 1, 32'h2000_0000);
        check_val("t3_clear_busy", 32'(out_busy), 32'h1);
        in_move = MOVE_NONE;
        push_board(32'h2000_0002);
        wait_idle("t3_idle", 40);
        check_board("t3_respawn");

        // 4: single line clear, then two clears with a marker shifted by 2
        do_reset("t4");
        place("t4_a0", 0, 32'h1000_0002);
        place("t4_a1", 1, 32'h3000_0002);
        place("t4_a2", 2, 32'h7000_0002);
        place("t4_a3", 3, 32'h0000_0002);
        check_val("t4_lines1", 32'(out_lines), 32'd1);
        place("t4_b0", 0, 32'h1000_0002);
        place("t4_b1", 0, 32'h1100_0002);
        place("t4_b2", 0, 32'h1110_0002);
        place("t4_b3", 1, 32'h3110_0002);
        place("t4_b4", 1, 32'h3310_0002);
        place("t4_b5", 2, 32'h7310_0002);
        place("t4_b6", 2, 32'h7710_0002);
        place("t4_b7", 3, 32'h7100_0002);
        check_val("t4_lines2", 32'(out_lines), 32'd2);
        place("t4_b8", 3, 32'h1000_0002);
        check_val("t4_lines3", 32'(out_lines), 32'd3);

        // 5: column overflow -> game over
        do_reset("t5");
        col_model = 32'h0000_0002;
        for (int k = 0; k < 7; k++) begin
            col_model = col_model | (32'h1 << ((7 - k) * 4 + 1));
            place($sformatf("t5_p%0d", k), 1, col_model);
        end
        check_val("t5_full_col", out_board, 32'h2222_2222);
        check_val("t5_not_over", 32'(out_game_over), 32'h0);
        place("t5_last", 1, 32'h2222_2222);
        check_val("t5_over", 32'(out_game_over), 32'h1);
        in_move = MOVE_LEFT;
        expect_board("t5_frozen_left", 5, 32'h2222_2222);
        in_move = MOVE_DROP;
        expect_board("t5_frozen_drop", 3, 32'h2222_2222);
        check_val("t5_still_over", 32'(out_game_over), 32'h1);
        check_val("t5_over_busy", 32'(out_busy), 32'h0);
        in_move = MOVE_NONE;

        // 6: asynchronous reset in the middle of CLEAR
        do_reset("t6");
        place("t6_p0", 0, 32'h1000_0002);
        place("t6_p1", 0, 32'h1100_0002);
        place("t6_p2", 1, 32'h3100_0002);
        place("t6_p3", 2, 32'h7100_0002);
        in_move = MOVE_RIGHT;
        step(2);
        in_move = MOVE_DROP;
        step(1);
        in_move = MOVE_NONE;
        wait_busy("t6_lock", 40);
        expect_board("t6_clear_full", 1, 32'hF100_0000);
        expect_board("t6_clear_shift", 1, 32'h1000_0000);
        check_val("t6_lines_pre", 32'(out_lines), 32'd1);
        #3;
        in_restart_n = 1'b0;
        #1;
        check_val("t6_async_board", out_board, 32'h0);
        check_val("t6_async_lines", 32'(out_lines), 32'h0);
        check_val("t6_async_over", 32'(out_game_over), 32'h0);
        check_val("t6_async_busy", 32'(out_busy), 32'h1);
        @(negedge in_clk);
        in_restart_n = 1'b1;
        #1;
        check_val("t6_spawn_board", out_board, 32'h0);
        expect_board("t6_after_spawn", 1, 32'h0000_0002);
        check_val("t6_after_busy", 32'(out_busy), 32'h0);

        // ---------------- report ----------------
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain obs=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
